// File: rtl/seg_scan_display_pkg.sv
// seg_scan_display_pkg
//   Shared constants for the 7-segment scanner: the all-off segment pattern,
//   the decimal-point bit position and the leading-zero mask helper.
//   The optional leading-zero feature is LEADING_ZERO_SUPPRESS_EN; the helper
//   is always present but only referenced when that macro is defined.
package seg_scan_display_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;

    // Bit i set when digit i (i >= 1) is a leading zero, i.e. it and every
    // nibble above it are zero. Digit 0 is never marked.
    function automatic logic [15:0] lz_mask(input logic [63:0] word, input int digits);
        logic [15:0] m;
        logic        seen;
        m    = '0;
        seen = 1'b0;
        for (int i = 15; i >= 1; i--) begin
            if (i < digits) begin
                if (word[4*i +: 4] != 4'h0) seen = 1'b1;
                m[i] = ~seen;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// seg_scan_display_if
//   Bundles the display data/control inputs and the LED pin outputs.
//   slave  : the scanner (consumes i_*, drives o_*)
//   master : the driving logic (drives i_*, observes o_*)
interface seg_scan_display_if #(parameter int DIGITS = 4);

    logic [4*DIGITS-1:0] i_data_in;
    logic                i_load;
    logic                i_pause;
    logic [DIGITS-1:0]   i_blank_mask;
    logic [DIGITS-1:0]   i_dp_mask;
    logic [DIGITS-1:0]   o_led_id;
    logic [7:0]          o_out_led;
    logic                o_frame_done;

    modport slave (
        input  i_data_in, i_load, i_pause, i_blank_mask, i_dp_mask,
        output o_led_id, o_out_led, o_frame_done
    );

    modport master (
        output i_data_in, i_load, i_pause, i_blank_mask, i_dp_mask,
        input  o_led_id, o_out_led, o_frame_done
    );

endinterface

// File: rtl/seg_scan_display_hex_to_seg7.sv
// hex_to_seg7
//   Combinational hex nibble to active-low 7-segment code ([6:0] = g..a).
//   i_nibble : 4-bit hex value
//   o_seg    : segment pattern, 0 = segment lit
module hex_to_seg7 (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        case (i_nibble)
            4'h0: o_seg = 7'h40;
            4'h1: o_seg = 7'h79;
            4'h2: o_seg = 7'h24;
            4'h3: o_seg = 7'h30;
            4'h4: o_seg = 7'h19;
            4'h5: o_seg = 7'h12;
            4'h6: o_seg = 7'h02;
            4'h7: o_seg = 7'h78;
            4'h8: o_seg = 7'h00;
            4'h9: o_seg = 7'h10;
            4'hA: o_seg = 7'h08;
            4'hB: o_seg = 7'h03;
            4'hC: o_seg = 7'h46;
            4'hD: o_seg = 7'h21;
            4'hE: o_seg = 7'h06;
            4'hF: o_seg = 7'h0E;
            default: o_seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed DIGITS-digit hex scanner with double-buffered data, per-digit
//   dwell of PRESCALE clocks, pause freeze, blanking and decimal points.
//   clk   : system clock (rising edge)
//   rst_n : synchronous active-low reset
//   bus   : seg_scan_display_if.slave (data/load/pause/masks in,
//           led_id/out_led/frame_done out, all active-low LED pins)
//   Optional: define LEADING_ZERO_SUPPRESS_EN to blank leading zero digits.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_scan_display_if.slave   bus
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    r_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_active;
    logic [4*DIGITS-1:0] r_pending;
    logic                r_pend_flag;
    logic                r_wrap_d;
    logic [DIGITS-1:0]   r_led_id;
    logic [7:0]          r_out_led;
    logic                r_frame_done;

    logic                w_dwell_end;
    logic                w_frame_wrap;
    logic                w_commit;
    logic [4*DIGITS-1:0] w_active_nxt;
    logic [IDX_W+1:0]    w_bit_base;
    logic [3:0]          w_nib;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_lz_cur;
    logic [7:0]          w_seg_out;

    assign w_dwell_end  = (r_cnt == CNT_W'(PRESCALE - 1));
    assign w_frame_wrap = ~bus.i_pause & w_dwell_end & (r_idx == IDX_W'(DIGITS - 1));
    // A load coinciding with the wrap bypasses the pending buffer.
    assign w_commit     = w_frame_wrap & (bus.i_load | r_pend_flag);
    assign w_active_nxt = bus.i_load ? bus.i_data_in : r_pending;

    assign w_bit_base = {r_idx, 2'b00};
    assign w_nib      = r_active[w_bit_base +: 4];

    hex_to_seg7 u_hex (
        .i_nibble (w_nib),
        .o_seg    (w_seg)
    );

`ifdef LEADING_ZERO_SUPPRESS_EN
    localparam logic [15:0] LZ_RST = lz_mask(64'd0, DIGITS);
    logic [DIGITS-1:0] r_lz_mask;
    logic [15:0]       w_lz_full;

    // Mask follows active, so it is only re-evaluated on a commit.
    assign w_lz_full = lz_mask(64'(w_active_nxt), DIGITS);
    assign w_lz_cur  = r_lz_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lz_mask <= LZ_RST[DIGITS-1:0];
        end else if (w_commit) begin
            r_lz_mask <= w_lz_full[DIGITS-1:0];
        end
    end
`else
    assign w_lz_cur = '0;
`endif

    always_comb begin
        w_seg_out = {~bus.i_dp_mask[r_idx], w_seg};
        if (bus.i_blank_mask[r_idx]) begin
            w_seg_out = SEG_OFF;
        end else if (w_lz_cur[r_idx]) begin
            w_seg_out = {~bus.i_dp_mask[r_idx], 7'h7F};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_active     <= '0;
            r_pending    <= '0;
            r_pend_flag  <= 1'b0;
            r_wrap_d     <= 1'b0;
            r_led_id     <= '1;
            r_out_led    <= SEG_OFF;
            r_frame_done <= 1'b0;
        end else begin
            if (bus.i_load) r_pending <= bus.i_data_in;
            if (w_frame_wrap)    r_pend_flag <= 1'b0;
            else if (bus.i_load) r_pend_flag <= 1'b1;
            if (w_commit) r_active <= w_active_nxt;

            if (!bus.i_pause) begin
                if (w_dwell_end) begin
                    r_cnt <= '0;
                    r_idx <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_led_id     <= ~(DIGITS'(1) << r_idx);
                r_out_led    <= w_seg_out;
                // Delayed one scan step so the pulse lands with digit 0's select.
                r_wrap_d     <= w_frame_wrap;
                r_frame_done <= r_wrap_d;
            end else begin
                r_frame_done <= 1'b0;
            end
        end
    end

    assign bus.o_led_id     = r_led_id;
    assign bus.o_out_led    = r_out_led;
    assign bus.o_frame_done = r_frame_done;

endmodule
